// File: rtl/scope_trigger_if.sv
// rtl/scope_trigger_if.sv - trigger configuration, probe bus and scope-side signal bundle
interface scope_trigger_if #(
  parameter int WIDTH      = 64,
  parameter int DEPTH_LOG2 = 14,
  parameter int OCC_BITS   = 8
);
  // control pulses
  logic                  arm;
  logic                  abort;

  // trigger configuration, latched on arm
  logic [WIDTH-1:0]      trig_mask;
  logic [WIDTH-1:0]      trig_value;
  logic                  trig_edge;
  logic [OCC_BITS-1:0]   trig_occ;
  logic [DEPTH_LOG2-1:0] post_count;

  // probe in, scope feed out
  logic [WIDTH-1:0]      trace_in;
  logic [WIDTH-1:0]      trace_out;
  logic                  trace_en;

  // status
  logic                  armed;
  logic                  done;
  logic [OCC_BITS-1:0]   occ_left;

  modport master (
    output arm, abort, trig_mask, trig_value, trig_edge, trig_occ, post_count, trace_in,
    input  trace_out, trace_en, armed, done, occ_left
  );

  modport slave (
    input  arm, abort, trig_mask, trig_value, trig_edge, trig_occ, post_count, trace_in,
    output trace_out, trace_en, armed, done, occ_left
  );
endinterface

// File: rtl/scope_trigger.sv
// rtl/scope_trigger.sv - mask/value trigger sequencer owning the trace scope capture enable
module scope_trigger #(
  parameter int WIDTH      = 64,
  parameter int DEPTH_LOG2 = 14,
  parameter int OCC_BITS   = 8
) (
  input logic             clk,
  input logic             reset,
  scope_trigger_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t                state;
  state_t                state_next;

  // configuration captured at arm so software may reprogram inputs mid-run
  logic [WIDTH-1:0]      mask_l;
  logic [WIDTH-1:0]      value_l;
  logic                  edge_l;
  logic [DEPTH_LOG2-1:0] post_count_l;

  logic [DEPTH_LOG2-1:0] cap_cnt;
  logic [DEPTH_LOG2-1:0] cap_cnt_next;
  logic [OCC_BITS-1:0]   occ_left;
  logic [OCC_BITS-1:0]   occ_left_next;
  logic                  prev_match;
  logic                  prev_match_next;
  logic                  latch_cfg;

  logic                  match;
  logic                  trig_event;

  logic [WIDTH-1:0]      trace_out_r;
  logic                  trace_en_r;
  logic                  armed_r;
  logic                  done_r;

  // compare against the raw probe so the trigger sample lands in trace_out on the firing edge
  assign match      = (((bus.trace_in ^ value_l) & mask_l) == '0);
  assign trig_event = edge_l ? (match & ~prev_match) : match;

  // next-state and counter updates; abort outranks arm, arm outranks the search/capture
  always_comb begin
    state_next      = state;
    cap_cnt_next    = cap_cnt;
    occ_left_next   = occ_left;
    prev_match_next = prev_match;
    latch_cfg       = 1'b0;

    if (bus.abort) begin
      state_next = IDLE;
    end else if (bus.arm && (state == IDLE || state == DONE)) begin
      state_next      = ARMED;
      latch_cfg       = 1'b1;
      occ_left_next   = bus.trig_occ;
      // a condition already true at arm must go false first before edge mode counts it
      prev_match_next = 1'b1;
    end else begin
      case (state)
        ARMED: begin
          prev_match_next = match;
          if (trig_event) begin
            if (occ_left == '0) begin
              state_next   = CAPTURE;
              cap_cnt_next = post_count_l;
            end else begin
              occ_left_next = occ_left - 1'b1;
            end
          end
        end
        CAPTURE: begin
          if (cap_cnt == '0) begin
            state_next = DONE;
          end else begin
            cap_cnt_next = cap_cnt - 1'b1;
          end
        end
        default: begin
          state_next = state;
        end
      endcase
    end
  end

  // state, counters and registered status decodes of the next state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cap_cnt    <= '0;
      occ_left   <= '0;
      prev_match <= 1'b0;
      trace_en_r <= 1'b0;
      armed_r    <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state      <= state_next;
      cap_cnt    <= cap_cnt_next;
      occ_left   <= occ_left_next;
      prev_match <= prev_match_next;
      trace_en_r <= (state_next == CAPTURE);
      armed_r    <= (state_next == ARMED);
      done_r     <= (state_next == DONE);
    end
  end

  // trigger configuration latch; kept across abort so a re-arm is the only way to change it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask_l       <= '0;
      value_l      <= '0;
      edge_l       <= 1'b0;
      post_count_l <= '0;
    end else if (latch_cfg) begin
      mask_l       <= bus.trig_mask;
      value_l      <= bus.trig_value;
      edge_l       <= bus.trig_edge;
      post_count_l <= bus.post_count;
    end
  end

  // unconditional one-cycle probe delay aligning data with trace_en
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trace_out_r <= '0;
    end else begin
      trace_out_r <= bus.trace_in;
    end
  end

  assign bus.trace_out = trace_out_r;
  assign bus.trace_en  = trace_en_r;
  assign bus.armed     = armed_r;
  assign bus.done      = done_r;
  assign bus.occ_left  = occ_left;

endmodule

// File: tb/tb_scope_trigger.sv
// tb/tb_scope_trigger.sv - directed self-checking bench for scope_trigger
module tb_scope_trigger;

  logic clk;
  logic reset;
  int   total_cnt;
  int   pass_cnt;

  scope_trigger_if #(.WIDTH(64), .DEPTH_LOG2(14), .OCC_BITS(8)) bus ();

  scope_trigger #(.WIDTH(64), .DEPTH_LOG2(14), .OCC_BITS(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      pass_cnt++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm(input logic [63:0] m, input logic [63:0] v, input logic e,
                        input logic [7:0] occ, input logic [13:0] pc);
    bus.trig_mask  = m;
    bus.trig_value = v;
    bus.trig_edge  = e;
    bus.trig_occ   = occ;
    bus.post_count = pc;
    bus.arm        = 1'b1;
    step();
    bus.arm        = 1'b0;
  endtask

  task automatic pulse_abort();
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
  endtask

  initial begin
    logic [63:0] cap [4];
    int          n_en;
    int          first_i;
    int          steps;
    int          pat [15];

    total_cnt = 0;
    pass_cnt  = 0;
    reset          = 1'b1;
    bus.arm        = 1'b0;
    bus.abort      = 1'b0;
    bus.trig_mask  = '0;
    bus.trig_value = '0;
    bus.trig_edge  = 1'b0;
    bus.trig_occ   = '0;
    bus.post_count = '0;
    bus.trace_in   = 64'h1234;

    // reset state
    #3;
    check("rst_trace_en", {63'd0, bus.trace_en}, 64'd0);
    check("rst_armed", {63'd0, bus.armed}, 64'd0);
    check("rst_done", {63'd0, bus.done}, 64'd0);
    check("rst_occ_left", {56'd0, bus.occ_left}, 64'd0);
    check("rst_trace_out", bus.trace_out, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    step();
    check("pipe_trace_out", bus.trace_out, 64'h1234);

    // level trigger on 0x5A, post_count 3
    bus.trace_in = 64'h50;
    do_arm(64'hFF, 64'h5A, 1'b0, 8'd0, 14'd3);
    check("lvl_armed", {63'd0, bus.armed}, 64'd1);
    n_en    = 0;
    first_i = -1;
    for (int i = 0; i < 20; i++) begin
      bus.trace_in = 64'h51 + 64'(i);
      step();
      if (bus.trace_en) begin
        if (n_en < 4) cap[n_en] = bus.trace_out;
        if (first_i < 0) first_i = i;
        n_en++;
      end
    end
    check("lvl_first_cycle", 64'(first_i), 64'd9);
    check("lvl_en_cycles", 64'(n_en), 64'd4);
    for (int k = 0; k < 4; k++) check("lvl_capture", cap[k], 64'h5A + 64'(k));
    check("lvl_done", {63'd0, bus.done}, 64'd1);
    check("lvl_not_armed", {63'd0, bus.armed}, 64'd0);

    // rising-edge trigger on bit 0, third rising edge fires, 2-sample capture
    pat = '{1, 1, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0, 1, 1, 0};
    bus.trace_in = 64'hA1;
    do_arm(64'h1, 64'h1, 1'b1, 8'd2, 14'd1);
    check("edg_occ_init", {56'd0, bus.occ_left}, 64'd2);
    for (int i = 0; i < 15; i++) begin
      bus.trace_in = 64'hA0 | 64'(pat[i]);
      step();
      case (i)
        3:  check("edg_occ_held_high", {56'd0, bus.occ_left}, 64'd2);
        7:  check("edg_occ_first", {56'd0, bus.occ_left}, 64'd1);
        11: begin
          check("edg_occ_second", {56'd0, bus.occ_left}, 64'd0);
          check("edg_no_en_yet", {63'd0, bus.trace_en}, 64'd0);
        end
        12: begin
          check("edg_fire_en", {63'd0, bus.trace_en}, 64'd1);
          check("edg_fire_data", bus.trace_out, 64'hA1);
        end
        13: check("edg_en_second", {63'd0, bus.trace_en}, 64'd1);
        14: begin
          check("edg_en_off", {63'd0, bus.trace_en}, 64'd0);
          check("edg_done", {63'd0, bus.done}, 64'd1);
        end
        default: ;
      endcase
    end

    // abort from DONE, then arm and abort together in IDLE
    pulse_abort();
    check("abt_idle_done", {63'd0, bus.done}, 64'd0);
    bus.abort = 1'b1;
    do_arm(64'h0, 64'h0, 1'b0, 8'd0, 14'd10);
    bus.abort = 1'b0;
    check("race_armed", {63'd0, bus.armed}, 64'd0);
    check("race_en", {63'd0, bus.trace_en}, 64'd0);

    // mask 0 in edge mode never fires
    do_arm(64'h0, 64'h0, 1'b1, 8'd0, 14'd10);
    for (int i = 0; i < 5; i++) step();
    check("m0_edge_armed", {63'd0, bus.armed}, 64'd1);
    check("m0_edge_en", {63'd0, bus.trace_en}, 64'd0);
    pulse_abort();
    check("m0_edge_abort", {63'd0, bus.armed}, 64'd0);

    // mask 0 level mode fires on first ARMED cycle; abort during capture
    do_arm(64'h0, 64'h0, 1'b0, 8'd0, 14'd10);
    step();
    check("m0_lvl_fire", {63'd0, bus.trace_en}, 64'd1);
    step();
    pulse_abort();
    check("cap_abort_en", {63'd0, bus.trace_en}, 64'd0);
    for (int i = 0; i < 12; i++) step();
    check("cap_abort_done", {63'd0, bus.done}, 64'd0);
    check("cap_abort_en_later", {63'd0, bus.trace_en}, 64'd0);

    // asynchronous reset in the middle of a capture
    do_arm(64'h0, 64'h0, 1'b0, 8'd0, 14'd100);
    step();
    step();
    check("rcap_en_before", {63'd0, bus.trace_en}, 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check("rcap_en_async", {63'd0, bus.trace_en}, 64'd0);
    check("rcap_trace_out", bus.trace_out, 64'd0);
    check("rcap_armed", {63'd0, bus.armed}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    n_en = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.trace_en) n_en++;
    end
    check("rcap_no_en", 64'(n_en), 64'd0);

    // full depth capture with an ignored arm in the middle
    do_arm(64'h0, 64'h0, 1'b0, 8'd0, 14'd16383);
    n_en  = 0;
    steps = 0;
    while (!bus.done && steps < 17000) begin
      if (steps == 100) begin
        bus.post_count = 14'd5;
        bus.arm        = 1'b1;
      end else begin
        bus.arm = 1'b0;
      end
      step();
      steps++;
      if (bus.trace_en) n_en++;
      if (steps == 101) check("full_arm_ignored", {63'd0, bus.trace_en}, 64'd1);
    end
    check("full_en_cycles", 64'(n_en), 64'd16384);
    check("full_done", {63'd0, bus.done}, 64'd1);
    step();
    check("full_en_off", {63'd0, bus.trace_en}, 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/scope_trigger.md
Name: scope_trigger

Overview:
Capture sequencer that sits in front of the 64-bit trace scope and owns its trace_en input. Software or a debug UART arms the block with a mask/value trigger, an edge/level mode, an occurrence count and a post-trigger length. On the qualifying trigger it raises trace_en for exactly the programmed number of samples, then drops it so the scope plays the capture back. trace_in is delayed one cycle into trace_out, so the trigger sample is the first word the scope stores.

Parameters:
WIDTH, 64, trace word width; must equal the scope width.
DEPTH_LOG2, 14, post-count width; 2^DEPTH_LOG2 equals the scope depth.
OCC_BITS, 8, occurrence counter width.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
arm  input  1  one-cycle pulse: latch the config and start the trigger search
abort  input  1  one-cycle pulse: return to IDLE from any state
trig_mask  input  WIDTH  bits compared (1 = compare)
trig_value  input  WIDTH  compare value
trig_edge  input  1  0 = level trigger, 1 = rising edge of the match condition
trig_occ  input  OCC_BITS  fire on match event number trig_occ+1
post_count  input  DEPTH_LOG2  samples captured minus 1
trace_in  input  WIDTH  probe bus
trace_out  output  WIDTH  trace_in registered one cycle; feeds scope trace_in
trace_en  output  1  registered; high only in CAPTURE; feeds scope trace_en
armed  output  1  high in ARMED
done  output  1  high in DONE
occ_left  output  OCC_BITS  remaining events before fire (debug)

Behaviour:
- Reset: the asynchronous assert forces state=IDLE. trace_out, trace_en, armed, done, occ_left, the latched config, cap_cnt and prev_match all go to 0.
- trace_out <= trace_in every cycle in every state. The pipeline is unconditional.
- States (2-bit): IDLE, ARMED, CAPTURE, DONE. Outputs are registered decodes of the next state:
  - trace_en = (state==CAPTURE)
  - armed = (state==ARMED)
  - done = (state==DONE)
- Priority: abort > arm > internal transitions.
- abort in any state: the next state is IDLE. trace_en falls on the following edge. Latched config is kept.
- arm in IDLE or DONE: the next state is ARMED.
  - Latch mask, value, edge, post_count.
  - occ_left <= trig_occ.
  - prev_match <= 1, so edge mode needs a false->true transition after arm.
- arm in ARMED or CAPTURE: ignored.
- ARMED, evaluated every cycle on the raw trace_in:
  - match = (((trace_in ^ value_l) & mask_l) == 0)
  - event = edge_l ? (match & ~prev_match) : match
  - prev_match <= match
  - If event and occ_left==0: go to CAPTURE and set cap_cnt <= post_count_l.
  - If event and occ_left!=0: occ_left <= occ_left-1 and stay in ARMED.
- Trigger latency: trigger sample at edge N. trace_en is high from edge N+1, when trace_out also holds that sample. The scope writes it at address 0.
- CAPTURE: cap_cnt decrements each cycle.
  - When cap_cnt==0, the next state is DONE.
  - trace_en is high for exactly post_count_l+1 cycles.
  - post_count = 2^DEPTH_LOG2-1 fills the scope exactly. No wrap, and no count beyond depth is possible.
- DONE: trace_en low (the scope replays), done=1. Stays until arm or abort.
- Boundaries:
  - mask=0 gives match=1 always. Level mode fires on the first ARMED cycle. Edge mode never fires; this is documented and legal, and abort recovers.
  - post_count=0 captures 1 sample.
  - trig_occ=0 fires on the first event.
  - Edge mode counts only rising edges. A match held high counts once.
  - arm and abort in the same cycle: abort wins, state=IDLE.
  - Reset mid-CAPTURE: trace_en drops immediately and asynchronously. The scope address resets when re-enabled.
- Between CAPTURE runs, trace_en is low for at least 1 cycle. This guarantees the scope write address returns to 0.

Test Plan:
- Reset mid-CAPTURE: all outputs 0 asynchronously; no further trace_en until a new arm.
- Level trigger: mask=0xFF, value=0x5A, occ=0, post_count=3; trace_in counts 0x50..0x60 each cycle.
  - trace_en is high for 4 cycles starting the cycle after trace_in=0x5A.
  - trace_out during those cycles = 0x5A, 0x5B, 0x5C, 0x5D.
  - done=1 afterwards.
- Edge plus occurrence: edge=1, occ=2, mask=1, value=1; trace_in[0] held 1 at arm, then toggles 0/1 every 2 cycles.
  - The held-high level at arm does not count.
  - occ_left steps 2, 1, 0 on successive rising edges; the fire occurs on the 3rd rising edge.
- Abort/arm race: arm and abort asserted together in IDLE leaves state IDLE. abort during CAPTURE drops trace_en the next cycle, and done stays 0.
- Full depth: post_count=16383 gives trace_en high for exactly 16384 cycles, then DONE. An arm during CAPTURE is ignored.
